// File: rtl/breath_pkg.sv
// Shared types and default constants for the breathing-LED ramp generator.
package breath_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_e;

  localparam int DUTY_W_DEF     = 8;
  localparam int STEP_DIV_DEF   = 46875;
  localparam int HOLD_STEPS_DEF = 64;

endpackage

// File: rtl/breath_tick.sv
// Ramp-step prescaler: counts 0..STEP_DIV-1 while running and parks on the
// last count while the downstream stage has not taken the pending duty.
module breath_tick
  import breath_pkg::*;
#(
  parameter int STEP_DIV = STEP_DIV_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  input  logic freeze,
  output logic tick
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count_r;

  // Prescaler count, held at LAST while a tick cannot be acted on.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_r <= {CW{1'b0}};
    end else if (!run) begin
      count_r <= {CW{1'b0}};
    end else if (count_r == LAST) begin
      if (freeze) begin
        count_r <= count_r;
      end else begin
        count_r <= {CW{1'b0}};
      end
    end else begin
      count_r <= count_r + ONE;
    end
  end

  assign tick = run & (count_r == LAST);

endmodule

// File: rtl/breath_ramp.sv
// Triangle "breathing" duty generator with hold plateaus and a valid/ready
// handoff to a PWM stage. Define BREATH_GAMMA_EN for a squared (gamma) curve.
module breath_ramp
  import breath_pkg::*;
#(
  parameter int DUTY_W     = DUTY_W_DEF,
  parameter int STEP_DIV   = STEP_DIV_DEF,
  parameter int HOLD_STEPS = HOLD_STEPS_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  input  logic              duty_ready,
  output logic [2:0]        phase,
  output logic              cycle_done
);

  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [DUTY_W-1:0] LEVEL_MAX = {DUTY_W{1'b1}};
  localparam logic [DUTY_W-1:0] LEVEL_ONE = DUTY_W'(1);
  localparam bit NO_HOLD = (HOLD_STEPS == 0);

  state_e            state_r;
  logic [DUTY_W-1:0] level_r;
  logic [HW-1:0]     hold_r;
  logic [DUTY_W-1:0] level_inc_s;
  logic [DUTY_W-1:0] level_dec_s;
  logic              run_s;
  logic              freeze_s;
  logic              tick_s;
  logic              act_s;

  // Maps a ramp level to the duty value presented downstream.
  function automatic logic [DUTY_W-1:0] shape(input logic [DUTY_W-1:0] lv);
`ifdef BREATH_GAMMA_EN
    logic [2*DUTY_W-1:0] sq;
    sq = {{DUTY_W{1'b0}}, lv} * {{DUTY_W{1'b0}}, lv};
    return sq[2*DUTY_W-1:DUTY_W];
`else
    return lv;
`endif
  endfunction

  breath_tick #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk   (clk),
    .rstn  (rstn),
    .run   (run_s),
    .freeze(freeze_s),
    .tick  (tick_s)
  );

  // Tick qualification and saturating level arithmetic.
  always_comb begin
    run_s    = en & (state_r != IDLE);
    freeze_s = duty_valid & ~duty_ready;
    act_s    = tick_s & ~freeze_s;
    if (level_r == LEVEL_MAX) begin
      level_inc_s = level_r;
    end else begin
      level_inc_s = level_r + LEVEL_ONE;
    end
    if (level_r == {DUTY_W{1'b0}}) begin
      level_dec_s = level_r;
    end else begin
      level_dec_s = level_r - LEVEL_ONE;
    end
  end

  // Ramp FSM with registered duty handshake and cycle pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r    <= IDLE;
      level_r    <= {DUTY_W{1'b0}};
      hold_r     <= {HW{1'b0}};
      duty       <= {DUTY_W{1'b0}};
      duty_valid <= 1'b0;
      cycle_done <= 1'b0;
    end else if (!en) begin
      state_r    <= IDLE;
      level_r    <= {DUTY_W{1'b0}};
      hold_r     <= {HW{1'b0}};
      duty_valid <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      // A same-edge load below overrides this transfer-driven clear.
      if (duty_valid && duty_ready) begin
        duty_valid <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          state_r <= RISE;
          level_r <= {DUTY_W{1'b0}};
          hold_r  <= {HW{1'b0}};
        end
        RISE: begin
          if (act_s) begin
            level_r    <= level_inc_s;
            duty       <= shape(level_inc_s);
            duty_valid <= 1'b1;
            if (level_inc_s == LEVEL_MAX) begin
              state_r <= NO_HOLD ? FALL : HOLD_HI;
            end
          end
        end
        HOLD_HI: begin
          if (act_s) begin
            if (hold_r == HOLD_LAST) begin
              hold_r  <= {HW{1'b0}};
              state_r <= FALL;
            end else begin
              hold_r <= hold_r + HOLD_ONE;
            end
          end
        end
        FALL: begin
          if (act_s) begin
            level_r    <= level_dec_s;
            duty       <= shape(level_dec_s);
            duty_valid <= 1'b1;
            if (level_dec_s == {DUTY_W{1'b0}}) begin
              if (NO_HOLD) begin
                state_r    <= RISE;
                cycle_done <= 1'b1;
              end else begin
                state_r <= HOLD_LO;
              end
            end
          end
        end
        HOLD_LO: begin
          if (act_s) begin
            if (hold_r == HOLD_LAST) begin
              hold_r     <= {HW{1'b0}};
              state_r    <= RISE;
              cycle_done <= 1'b1;
            end else begin
              hold_r <= hold_r + HOLD_ONE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          level_r <= {DUTY_W{1'b0}};
          hold_r  <= {HW{1'b0}};
        end
      endcase
    end
  end

  assign phase = state_r;

endmodule

// File: tb/tb_breath_ramp.sv
// Self-checking bench for breath_ramp (DUTY_W=4, STEP_DIV=3, HOLD_STEPS=2 and 0).
module tb_breath_ramp;

  localparam int W = 4;

  typedef struct {
    logic         rstn;
    logic         en;
    logic         rdy;
    logic [W-1:0] duty;
    logic         vld;
    logic [2:0]   ph;
    logic         cd;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn, en, duty_ready;
  logic [W-1:0] duty;
  logic         duty_valid;
  logic [2:0]   phase;
  logic         cycle_done;

  logic         rstn_z, en_z, ready_z;
  logic [W-1:0] duty_z;
  logic         valid_z;
  logic [2:0]   phase_z;
  logic         done_z;

  int checks = 0;
  int errors = 0;

  breath_ramp #(.DUTY_W(W), .STEP_DIV(3), .HOLD_STEPS(2)) dut (
    .clk(clk), .rstn(rstn), .en(en), .duty(duty), .duty_valid(duty_valid),
    .duty_ready(duty_ready), .phase(phase), .cycle_done(cycle_done)
  );

  breath_ramp #(.DUTY_W(W), .STEP_DIV(3), .HOLD_STEPS(0)) dut_nh (
    .clk(clk), .rstn(rstn_z), .en(en_z), .duty(duty_z), .duty_valid(valid_z),
    .duty_ready(ready_z), .phase(phase_z), .cycle_done(done_z)
  );

  function automatic logic [W-1:0] shape(input int lv);
`ifdef BREATH_GAMMA_EN
    return W'((lv * lv) >> W);
`else
    return W'(lv);
`endif
  endfunction

  // Level after t acted ticks of a 34-tick breath (15 up, 2 hold, 15 down, 2 hold).
  function automatic int level_after(input int t);
    int kk;
    kk = t % 34;
    if (kk <= 15) return kk;
    if (kk <= 17) return 15;
    if (kk <= 32) return 32 - kk;
    return 0;
  endfunction

  function automatic bit posts(input int t);
    int kk;
    kk = t % 34;
    return (t > 0) && (((kk >= 1) && (kk <= 15)) || ((kk >= 18) && (kk <= 32)));
  endfunction

  function automatic int phase_after(input int t);
    int kk;
    kk = t % 34;
    if (kk <= 14) return 1;
    if (kk <= 16) return 2;
    if (kk <= 31) return 3;
    return 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl [9];
    int   t;

    rstn = 1'b0; en = 1'b0; duty_ready = 1'b1;
    rstn_z = 1'b0; en_z = 1'b0; ready_z = 1'b1;

    tbl[0] = '{1'b0, 1'b0, 1'b1, shape(0), 1'b0, 3'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, shape(0), 1'b0, 3'd0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, shape(0), 1'b0, 3'd1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, shape(0), 1'b0, 3'd1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, shape(0), 1'b0, 3'd1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, shape(1), 1'b1, 3'd1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, shape(1), 1'b0, 3'd1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, shape(1), 1'b0, 3'd1, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b1, shape(2), 1'b1, 3'd1, 1'b0};

    for (int i = 0; i < 9; i++) begin
      rstn = tbl[i].rstn; en = tbl[i].en; duty_ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d duty", i), duty, tbl[i].duty);
      chk($sformatf("vec%0d valid", i), duty_valid, tbl[i].vld);
      chk($sformatf("vec%0d phase", i), phase, tbl[i].ph);
      chk($sformatf("vec%0d done", i), cycle_done, tbl[i].cd);
    end

    // Free run continues from edge 6 after RISE entry through one full breath.
    for (int n = 7; n <= 110; n++) begin
      t = n / 3;
      step();
      chk($sformatf("run%0d duty", n), duty, shape(level_after(t)));
      chk($sformatf("run%0d valid", n), duty_valid, ((n % 3) == 0) && posts(t));
      chk($sformatf("run%0d phase", n), phase, phase_after(t));
      chk($sformatf("run%0d done", n), cycle_done, n == 102);
    end

    // Backpressure while duty=5 is pending.
    rstn = 1'b0; step(); step();
    rstn = 1'b1; en = 1'b1; duty_ready = 1'b1;
    for (int n = 0; n <= 14; n++) step();
    duty_ready = 1'b0;
    step();
    chk("bp post duty", duty, shape(5));
    chk("bp post valid", duty_valid, 1'b1);
    for (int j = 16; j <= 25; j++) begin
      step();
      chk($sformatf("bp%0d duty", j), duty, shape(5));
      chk($sformatf("bp%0d valid", j), duty_valid, 1'b1);
      if (j >= 17) chk($sformatf("bp%0d presc", j), dut.u_tick.count_r, 2);
    end
    duty_ready = 1'b1;
    step();
    chk("bp release duty", duty, shape(6));
    chk("bp release valid", duty_valid, 1'b1);

    // Reset in the middle of RISE, then restart latency.
    step(); step(); step();
    chk("mid duty7", duty, shape(7));
    chk("mid phase", phase, 3'd1);
    rstn = 1'b0;
    step();
    chk("mid rst duty", duty, shape(0));
    chk("mid rst phase", phase, 3'd0);
    chk("mid rst valid", duty_valid, 1'b0);
    rstn = 1'b1;
    step();
    chk("restart phase", phase, 3'd1);
    step(); step();
    chk("restart early valid", duty_valid, 1'b0);
    step();
    chk("restart duty1", duty, shape(1));
    chk("restart valid", duty_valid, 1'b1);

    // Abort via en=0 with a pending duty.
    en = 1'b0; duty_ready = 1'b0;
    step();
    chk("abort phase", phase, 3'd0);
    chk("abort valid", duty_valid, 1'b0);
    chk("abort duty kept", duty, shape(1));

    // HOLD_STEPS=0 instance: direct turnarounds.
    rstn_z = 1'b1; en_z = 1'b1;
    for (int n = 0; n <= 93; n++) begin
      step();
      if (n == 45) begin
        chk("nh top duty", duty_z, shape(15));
        chk("nh top phase", phase_z, 3'd3);
      end
      if (n == 48) begin
        chk("nh fall duty", duty_z, shape(14));
        chk("nh fall valid", valid_z, 1'b1);
      end
      if (n == 89 || n == 91) chk($sformatf("nh%0d done", n), done_z, 1'b0);
      if (n == 90) begin
        chk("nh bottom duty", duty_z, shape(0));
        chk("nh bottom valid", valid_z, 1'b1);
        chk("nh bottom phase", phase_z, 3'd1);
        chk("nh bottom done", done_z, 1'b1);
      end
      if (n == 93) begin
        chk("nh rise duty", duty_z, shape(1));
        chk("nh rise valid", valid_z, 1'b1);
        chk("nh rise done", done_z, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
